alu_multiciclo: RTL

- Parametrised, clocked successor of the combinational datapath ALU for the multicycle MIPS core.
- Single-cycle logic/arithmetic ops complete in one clock. MUL and DIV are iterative (shift-add, restoring division) instead of combinational `*` and `/`.
- Produces a full-width product/remainder in HI/LO registers.
- Start/busy/done handshake lets the control FSM stall on long ops.

---
 rtl/alu_multiciclo.sv | 128 ++++++++++++
 1 files changed

// File: rtl/alu_multiciclo.sv
// alu_multiciclo: clocked MIPS ALU with iterative MUL/DIV into hi/lo and a start/busy/done handshake.
// Define ALU_SHIFT_EN to add single-cycle SLL/SRL/SRA.
module alu_multiciclo #(
  parameter int WIDTH = 32,
  parameter int CW = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       selector,
  input  logic [WIDTH-1:0] Data1,
  input  logic [WIDTH-1:0] Data2,
  output logic [WIDTH-1:0] salida,
  output logic             zflag,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MUL  = 2'd1;
  localparam logic [1:0] DIV  = 2'd2;
  logic [1:0] state;
  logic [CW-1:0] cnt;
  logic [2*WIDTH-1:0] mc, acc, mul_sum;
  logic [WIDTH-1:0] mq, dv, rm, rm_n, q_n, alu_r;
  logic [WIDTH:0] div_sh;
  logic div_ge, last;
  assign zflag = salida == '0;
  assign busy = state != IDLE;
  assign last = cnt == CW'(WIDTH - 1);
  // mq doubles as multiplier (shifted right) and dividend/quotient (shifted left)
  assign mul_sum = acc + (mq[0] ? mc : '0);
  assign div_sh = {rm, mq[WIDTH-1]};
  assign div_ge = div_sh >= {1'b0, dv};
  assign rm_n = div_ge ? div_sh[WIDTH-1:0] - dv : div_sh[WIDTH-1:0];
  assign q_n = {mq[WIDTH-2:0], div_ge};
`ifdef ALU_SHIFT_EN
  logic [CW-2:0] sh;
  assign sh = Data2[CW-2:0];
`endif
  always_comb begin
    alu_r = Data2;
    case (selector)
      4'b0000: alu_r = Data1 & Data2;
      4'b0001: alu_r = Data1 | Data2;
      4'b0010: alu_r = Data1 + Data2;
      4'b0110: alu_r = Data1 - Data2;
      4'b0111: alu_r = {{(WIDTH-1){1'b0}}, Data1 < Data2};
      4'b0101: alu_r = Data1 ^ Data2;
      4'b1100: alu_r = ~(Data1 | Data2);
`ifdef ALU_SHIFT_EN
      4'b0011: alu_r = Data1 << sh;
      4'b0100: alu_r = Data1 >> sh;
      4'b1001: alu_r = $unsigned($signed(Data1) >>> sh);
`endif
      default: alu_r = Data2;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      salida <= '0;
      hi <= '0;
      lo <= '0;
      done <= 1'b0;
      cnt <= '0;
      mc <= '0;
      acc <= '0;
      mq <= '0;
      dv <= '0;
      rm <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          if (selector == 4'b1000) begin
            mc <= {{WIDTH{1'b0}}, Data1};
            mq <= Data2;
            acc <= '0;
            cnt <= '0;
            state <= MUL;
          end else if (selector == 4'b1010 && Data2 != '0) begin
            mq <= Data1;
            dv <= Data2;
            rm <= '0;
            cnt <= '0;
            state <= DIV;
          end else if (selector == 4'b1010) begin
            lo <= '1;
            hi <= Data1;
            salida <= '1;
            done <= 1'b1;
          end else begin
            salida <= alu_r;
            done <= 1'b1;
          end
        end
        MUL: begin
          acc <= mul_sum;
          mc <= mc << 1;
          mq <= mq >> 1;
          cnt <= cnt + 1'b1;
          if (last) begin
            hi <= mul_sum[2*WIDTH-1:WIDTH];
            lo <= mul_sum[WIDTH-1:0];
            salida <= mul_sum[WIDTH-1:0];
            done <= 1'b1;
            state <= IDLE;
          end
        end
        DIV: begin
          rm <= rm_n;
          mq <= q_n;
          cnt <= cnt + 1'b1;
          if (last) begin
            hi <= rm_n;
            lo <= q_n;
            salida <= q_n;
            done <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
